// File: rtl/present_round_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// present_pkg
//   Shared definitions for the iterative PRESENT-80 encryption controller:
//   - datapath widths and the default round count
//   - controller FSM state type {IDLE, RUN, DONE}
//   - the 4-bit S-box (table + function), the 64-bit sLayer and pLayer
//   - the 80-bit key-schedule step ks(k, r)
//   All functions are pure combinational helpers shared by the controller
//   and the round datapath.
// ----------------------------------------------------------------------------
package present_pkg;

    localparam int PT_W           = 64;
    localparam int KEY_W          = 80;
    localparam int ROUNDS_DEFAULT = 31;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } fsm_state_e;

    localparam logic [3:0] SBOX_TAB [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    function automatic logic [3:0] sbox(input logic [3:0] x);
        return SBOX_TAB[x];
    endfunction

    // Sixteen parallel S-boxes across the 64-bit state.
    function automatic logic [PT_W-1:0] slayer(input logic [PT_W-1:0] s);
        logic [PT_W-1:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[4*i +: 4] = sbox(s[4*i +: 4]);
        end
        return r;
    endfunction

    // Bit i moves to position 16*i mod 63; bit 63 stays in place.
    function automatic logic [PT_W-1:0] player(input logic [PT_W-1:0] s);
        logic [PT_W-1:0] r;
        r = '0;
        for (int i = 0; i < 63; i++) begin
            r[(16*i) % 63] = s[i];
        end
        r[63] = s[63];
        return r;
    endfunction

    // One key-schedule step: rotate left by 61, S-box the top nibble,
    // fold the round counter into bits [19:15].
    function automatic logic [KEY_W-1:0] key_update(input logic [KEY_W-1:0] k,
                                                    input logic [4:0]       r);
        logic [KEY_W-1:0] n;
        n          = {k[18:0], k[79:19]};
        n[79:76]   = sbox(n[79:76]);
        n[19:15]   = n[19:15] ^ r;
        return n;
    endfunction

endpackage

// File: rtl/present_round_ctrl_if.sv
// ----------------------------------------------------------------------------
// present_round_ctrl_if
//   Input (plaintext/key) and output (ciphertext) handshakes of the
//   PRESENT-80 controller.
//
//   Handshake rule (both channels): a transfer happens on a rising clock
//   edge where valid and ready are both high. The producer holds its data
//   stable while valid is high; the controller's in_ready and out_valid are
//   functions of its FSM state only, never of the partner's valid/ready.
//
//   Signals
//     in_valid  : plaintext/key offered          (master -> slave)
//     in_ready  : controller can accept          (slave  -> master)
//     in_pt     : 64-bit plaintext               (master -> slave)
//     in_key    : 80-bit key                     (master -> slave)
//     out_valid : ciphertext available           (slave  -> master)
//     out_ready : consumer takes ciphertext      (master -> slave)
//     out_ct    : 64-bit ciphertext              (slave  -> master)
//   Modports: master = environment/driver side, slave = controller side.
// ----------------------------------------------------------------------------
interface present_round_ctrl_if;
    import present_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [PT_W-1:0]  in_pt;
    logic [KEY_W-1:0] in_key;
    logic             out_valid;
    logic             out_ready;
    logic [PT_W-1:0]  out_ct;

    modport master (
        output in_valid, in_pt, in_key, out_ready,
        input  in_ready, out_valid, out_ct
    );

    modport slave (
        input  in_valid, in_pt, in_key, out_ready,
        output in_ready, out_valid, out_ct
    );

endinterface

// File: rtl/present_round_ctrl_round.sv
// ----------------------------------------------------------------------------
// present_round
//   Combinational PRESENT round: addRoundKey, then sLayer, then pLayer.
//   Ports
//     state_i [63:0] : current cipher state
//     rkey_i  [63:0] : round key (top 64 bits of the key register)
//     state_o [63:0] : state after one full round
// ----------------------------------------------------------------------------
module present_round
    import present_pkg::*;
(
    input  logic [PT_W-1:0] state_i,
    input  logic [PT_W-1:0] rkey_i,
    output logic [PT_W-1:0] state_o
);

    logic [PT_W-1:0] ark;
    logic [PT_W-1:0] sl;

    assign ark     = state_i ^ rkey_i;
    assign sl      = slayer(ark);
    assign state_o = player(sl);

endmodule

// File: rtl/present_round_ctrl.sv
// ----------------------------------------------------------------------------
// present_round_ctrl
//   Iterative PRESENT-80 encryption controller. Accepts plaintext+key,
//   runs ROUNDS rounds through a 64-bit state register and an 80-bit key
//   register (one round per clock), then offers the ciphertext
//   state ^ key[79:16] until the consumer takes it.
//
//   Parameters
//     ROUNDS : round count, 1..31 (31 = standard PRESENT)
//     RC_W   : round-counter width, must hold ROUNDS
//   Ports
//     clk       : clock, all flops on the rising edge
//     rst       : asynchronous, active-high reset
//     bus       : present_round_ctrl_if.slave (in/out handshakes)
//     busy      : high in RUN or DONE
//     dbg_round : round counter, only with PRESENT_ROUND_DBG_EN defined
//
//   Build option: define PRESENT_ROUND_DBG_EN to add dbg_round.
//   dbg_round reads 0 in IDLE, 1..ROUNDS in RUN and ROUNDS+1 in DONE.
//   The counter carries one bit above RC_W so the DONE value ROUNDS+1
//   (32 with the defaults) is representable and the counter never wraps.
//
//   Timing: out_valid rises exactly ROUNDS clocks after the accepting edge;
//   with out_ready held high a new block can be accepted every ROUNDS+2
//   clocks.
// ----------------------------------------------------------------------------
module present_round_ctrl
    import present_pkg::*;
#(
    parameter int ROUNDS = ROUNDS_DEFAULT,
    parameter int RC_W   = 5
)
(
    input  logic                clk,
    input  logic                rst,
    present_round_ctrl_if.slave bus,
    output logic                busy
`ifdef PRESENT_ROUND_DBG_EN
    ,
    output logic [RC_W:0]       dbg_round
`endif
);

    localparam logic [RC_W:0] RND_LAST = (RC_W+1)'(ROUNDS);
    localparam logic [RC_W:0] RND_ONE  = (RC_W+1)'(1);

    fsm_state_e       fsm_q,   fsm_d;
    logic [PT_W-1:0]  state_q, state_d;
    logic [KEY_W-1:0] key_q,   key_d;
    logic [RC_W:0]    rnd_q,   rnd_d;

    logic             in_ready;
    logic             out_valid;
    logic [PT_W-1:0]  round_out;

    present_round u_round (
        .state_i (state_q),
        .rkey_i  (key_q[79:16]),
        .state_o (round_out)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
        end else begin
            fsm_q   <= fsm_d;
            state_q <= state_d;
            key_q   <= key_d;
            rnd_q   <= rnd_d;
        end
    end

    always_comb begin
        fsm_d     = fsm_q;
        state_d   = state_q;
        key_d     = key_q;
        rnd_d     = rnd_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;

        case (fsm_q)
            IDLE: begin
                in_ready = 1'b1;
                if (bus.in_valid) begin
                    state_d = bus.in_pt;
                    key_d   = bus.in_key;
                    rnd_d   = RND_ONE;
                    fsm_d   = RUN;
                end
            end

            RUN: begin
                // The key update uses the counter value of this round, so
                // round r produces K(r+1) alongside the new state.
                state_d = round_out;
                key_d   = key_update(key_q, rnd_q[4:0]);
                rnd_d   = rnd_q + RND_ONE;
                if (rnd_q == RND_LAST) begin
                    fsm_d = DONE;
                end
            end

            DONE: begin
                out_valid = 1'b1;
                if (bus.out_ready) begin
                    fsm_d = IDLE;
                    rnd_d = '0;
                end
            end

            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // Final addRoundKey is applied on the output path; both operands are
    // registers, so out_ct is stable for as long as DONE lasts.
    assign bus.out_ct    = state_q ^ key_q[79:16];
    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid;
    assign busy          = (fsm_q != IDLE);

`ifdef PRESENT_ROUND_DBG_EN
    assign dbg_round = rnd_q;
`endif

endmodule
